// File: rtl/asteroids_pkg.sv
// ============================================================================
// asteroids_pkg : constants and types shared by the torpedo launch logic
// Revision      : 1.0
// ============================================================================
`default_nettype none

package asteroids_pkg;

  localparam int T_NUM = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAUNCH   = 2'd1,
    COOLDOWN = 2'd2
  } torp_arb_state_t;

endpackage

`default_nettype wire

// File: rtl/torpedo_rr_pick.sv
// ============================================================================
// torpedo_rr_pick : combinational round-robin first-free slot finder
// Revision        : 1.0
// ============================================================================
`default_nettype none

module torpedo_rr_pick #(
  parameter int T_NUM = 4
) (
  input  logic [T_NUM-1:0]         eff_busy_i,
  input  logic [$clog2(T_NUM)-1:0] last_i,
  output logic [$clog2(T_NUM)-1:0] sel_o,
  output logic                     any_free_o
);

  localparam int IW = $clog2(T_NUM);

  logic [IW-1:0] cand;

  // Walk the offsets from farthest to nearest so the nearest free slot wins.
  always_comb begin
    sel_o      = '0;
    any_free_o = 1'b0;
    cand       = '0;
    for (int i = T_NUM; i >= 1; i--) begin
      cand = IW'((int'(last_i) + i) % T_NUM);
      if (!eff_busy_i[cand]) begin
        sel_o      = cand;
        any_free_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/torpedo_launch_arbiter.sv
// ============================================================================
// torpedo_launch_arbiter : round-robin torpedo slot allocator with cooldown
// Option macro           : TORPEDO_AUTOFIRE_EN (level-triggered autofire)
// Revision               : 1.0
// ============================================================================
`default_nettype none

module torpedo_launch_arbiter #(
  parameter int T_NUM           = asteroids_pkg::T_NUM,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int RESERVE_CYCLES  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fire_i,
  input  logic                     frame_tick_i,
  input  logic                     enable_i,
  input  logic [T_NUM-1:0]         slot_busy_i,
  output logic [T_NUM-1:0]         launch_o,
  output logic [$clog2(T_NUM)-1:0] slot_idx_o,
  output logic                     ready_o,
  output logic                     drop_o,
  output logic [15:0]              shots_o
);

  import asteroids_pkg::*;

  localparam int IW = $clog2(T_NUM);

  torp_arb_state_t state_q, state_d;
  logic [T_NUM-1:0] launch_q, launch_d;
  logic [IW-1:0]    slot_idx_q, slot_idx_d;
  logic [15:0]      shots_q, shots_d;
  logic             drop_q, drop_d;
  logic [7:0]       cd_q, cd_d;
  logic             res_vld_q, res_vld_d;
  logic [IW-1:0]    res_idx_q, res_idx_d;
  logic [1:0]       res_tmr_q, res_tmr_d;

  logic [T_NUM-1:0] reserved_mask;
  logic [T_NUM-1:0] eff_busy;
  logic [IW-1:0]    sel;
  logic             any_free;
  logic             req;

  always_comb begin
    reserved_mask = '0;
    if (res_vld_q) reserved_mask[res_idx_q] = 1'b1;
  end

  assign eff_busy = slot_busy_i | reserved_mask;

  torpedo_rr_pick #(
    .T_NUM (T_NUM)
  ) u_pick (
    .eff_busy_i (eff_busy),
    .last_i     (slot_idx_q),
    .sel_o      (sel),
    .any_free_o (any_free)
  );

`ifdef TORPEDO_AUTOFIRE_EN
  // hold_q silences a held trigger after it has produced one drop.
  logic hold_q, hold_d;

  assign req = fire_i & ~hold_q;

  always_comb begin
    hold_d = fire_i & (hold_q | ((state_q == IDLE) & req & enable_i & ~any_free));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hold_q <= 1'b0;
    else       hold_q <= hold_d;
  end
`else
  logic fire_d_q;

  assign req = fire_i & ~fire_d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fire_d_q <= 1'b0;
    else       fire_d_q <= fire_i;
  end
`endif

  always_comb begin
    state_d    = state_q;
    launch_d   = '0;
    drop_d     = 1'b0;
    slot_idx_d = slot_idx_q;
    shots_d    = shots_q;
    cd_d       = cd_q;
    res_vld_d  = res_vld_q;
    res_idx_d  = res_idx_q;
    res_tmr_d  = res_tmr_q;

    // Reservation ends once the unit reports busy or the timer runs out.
    if (res_vld_q) begin
      if (slot_busy_i[res_idx_q] || (res_tmr_q <= 2'd1)) begin
        res_vld_d = 1'b0;
        res_tmr_d = 2'd0;
      end else begin
        res_tmr_d = res_tmr_q - 2'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (req && enable_i) begin
          if (any_free) begin
            state_d        = LAUNCH;
            launch_d[sel]  = 1'b1;
            slot_idx_d     = sel;
            shots_d        = (shots_q == 16'hFFFF) ? shots_q : shots_q + 16'd1;
            res_vld_d      = 1'b1;
            res_idx_d      = sel;
            res_tmr_d      = 2'(RESERVE_CYCLES);
            cd_d           = 8'(COOLDOWN_FRAMES);
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      LAUNCH: begin
        if (enable_i) begin
          state_d = COOLDOWN;
        end else begin
          state_d = IDLE;
          cd_d    = 8'd0;
        end
      end
      COOLDOWN: begin
        if (!enable_i) begin
          state_d = IDLE;
          cd_d    = 8'd0;
        end else if (cd_q == 8'd0) begin
          state_d = IDLE;
        end else if (frame_tick_i) begin
          cd_d = cd_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      launch_q   <= '0;
      slot_idx_q <= IW'(T_NUM - 1);
      shots_q    <= 16'd0;
      drop_q     <= 1'b0;
      cd_q       <= 8'd0;
      res_vld_q  <= 1'b0;
      res_idx_q  <= '0;
      res_tmr_q  <= 2'd0;
    end else begin
      state_q    <= state_d;
      launch_q   <= launch_d;
      slot_idx_q <= slot_idx_d;
      shots_q    <= shots_d;
      drop_q     <= drop_d;
      cd_q       <= cd_d;
      res_vld_q  <= res_vld_d;
      res_idx_q  <= res_idx_d;
      res_tmr_q  <= res_tmr_d;
    end
  end

  assign launch_o   = launch_q;
  assign slot_idx_o = slot_idx_q;
  assign drop_o     = drop_q;
  assign shots_o    = shots_q;
  // Gated by reset so the port reads 0 while reset is held.
  assign ready_o    = ~reset & (state_q == IDLE) & enable_i & any_free;

endmodule

`default_nettype wire

// File: tb/tb_torpedo_launch_arbiter.sv
// ============================================================================
// tb_torpedo_launch_arbiter : two arbiters (cooldown 0 and 8) vs a timeline model
// Revision                  : 1.0
// ============================================================================
`default_nettype none

module tb_torpedo_launch_arbiter;

  localparam int T = 4;
  localparam int BIG = 1000000000;

  logic clk = 1'b0;
  logic reset;
  logic fire, tick, en;
  logic [T-1:0] busy [2];
  logic [T-1:0] launch_w [2];
  logic [1:0]   idx_w [2];
  logic         ready_w [2];
  logic         drop_w [2];
  logic [15:0]  shots_w [2];

  always #5 clk = ~clk;

  torpedo_launch_arbiter #(.T_NUM(T), .COOLDOWN_FRAMES(0), .RESERVE_CYCLES(3)) dut0 (
    .clk(clk), .reset(reset), .fire_i(fire), .frame_tick_i(tick), .enable_i(en),
    .slot_busy_i(busy[0]), .launch_o(launch_w[0]), .slot_idx_o(idx_w[0]),
    .ready_o(ready_w[0]), .drop_o(drop_w[0]), .shots_o(shots_w[0]));

  torpedo_launch_arbiter #(.T_NUM(T), .COOLDOWN_FRAMES(8), .RESERVE_CYCLES(3)) dut8 (
    .clk(clk), .reset(reset), .fire_i(fire), .frame_tick_i(tick), .enable_i(en),
    .slot_busy_i(busy[1]), .launch_o(launch_w[1]), .slot_idx_o(idx_w[1]),
    .ready_o(ready_w[1]), .drop_o(drop_w[1]), .shots_o(shots_w[1]));

  int checks = 0;
  int errors = 0;
  int ncd [2] = '{0, 8};

  // Timeline model: cycle stamps of the last launch, when acceptance resumes,
  // and the window during which the launched slot is held back.
  int cyc;
  int m_last [2], m_shots [2], m_idle_from [2], m_launch_cyc [2], m_ticks [2];
  int m_res_slot [2], m_res_from [2], m_res_end [2];
  logic m_prev_fire;
  logic [T-1:0] exp_launch [2];
  logic exp_drop [2];

  logic world_on;
  int   fly_len;
  int   fly_from [2][T], fly_to [2][T];
  logic [T-1:0] force_busy [2];

  task automatic model_init();
    cyc = 0;
    m_prev_fire = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_last[k] = T - 1; m_shots[k] = 0; m_idle_from[k] = 0; m_launch_cyc[k] = 0;
      m_ticks[k] = 0; m_res_slot[k] = -1; m_res_from[k] = 0; m_res_end[k] = 0;
      force_busy[k] = '0;
      for (int s = 0; s < T; s++) begin fly_from[k][s] = 0; fly_to[k][s] = 0; end
    end
    world_on = 1'b0;
    fly_len = 0;
  endtask

  task automatic do_reset(input bit chk);
    reset = 1'b1; fire = 1'b0; tick = 1'b0; en = chk; busy[0] = '0; busy[1] = '0;
    @(negedge clk); @(negedge clk);
    if (chk) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (launch_w[k] !== 4'b0 || idx_w[k] !== 2'd3 || ready_w[k] !== 1'b0 ||
            drop_w[k] !== 1'b0 || shots_w[k] !== 16'd0) begin
          errors++;
          $display("FAIL reset_values dut%0d got launch=%b idx=%0d ready=%b drop=%b shots=%0d want 0000/3/0/0/0",
                   k, launch_w[k], idx_w[k], ready_w[k], drop_w[k], shots_w[k]);
        end
      end
    end
    reset = 1'b0;
    model_init();
  endtask

  task automatic step(input logic f, input logic t, input logic e);
    fire = f; tick = t; en = e;
    for (int k = 0; k < 2; k++) begin
      busy[k] = force_busy[k];
      if (world_on)
        for (int s = 0; s < T; s++)
          if (cyc >= fly_from[k][s] && cyc < fly_to[k][s]) busy[k][s] = 1'b1;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      logic [T-1:0] freem;
      logic idle, anyf, req, resv;
      int pick;
      freem = ~busy[k];
      resv = (m_res_slot[k] >= 0) && (cyc >= m_res_from[k]) && (cyc < m_res_end[k]);
      if (resv) freem[m_res_slot[k]] = 1'b0;
      anyf = |freem;
      idle = (cyc >= m_idle_from[k]);
      checks++;
      if (ready_w[k] !== (idle & e & anyf)) begin
        errors++;
        $display("FAIL ready dut%0d cyc %0d got %b want %b", k, cyc, ready_w[k], idle & e & anyf);
      end
      req = f & ~m_prev_fire;
      exp_launch[k] = '0;
      exp_drop[k] = 1'b0;
      if (!idle && cyc >= m_launch_cyc[k]) begin
        if (!e) m_idle_from[k] = cyc + 1;
        else if (cyc > m_launch_cyc[k]) begin
          if (m_ticks[k] == ncd[k]) m_idle_from[k] = cyc + 1;
          else if (t) m_ticks[k]++;
        end
      end
      if (resv && busy[k][m_res_slot[k]]) m_res_end[k] = cyc + 1;
      if (idle && req && e) begin
        if (anyf) begin
          pick = -1;
          for (int i = 1; i <= T; i++)
            if (pick < 0 && freem[(m_last[k] + i) % T]) pick = (m_last[k] + i) % T;
          exp_launch[k][pick] = 1'b1;
          m_last[k] = pick;
          if (m_shots[k] < 65535) m_shots[k]++;
          m_launch_cyc[k] = cyc + 1;
          m_idle_from[k] = BIG;
          m_ticks[k] = 0;
          m_res_slot[k] = pick; m_res_from[k] = cyc + 1; m_res_end[k] = cyc + 4;
          if (world_on) begin
            fly_from[k][pick] = cyc + 3;
            fly_to[k][pick] = cyc + 3 + ((fly_len > 0) ? fly_len : int'($urandom_range(2, 25)));
          end
        end else begin
          exp_drop[k] = 1'b1;
        end
      end
    end
    m_prev_fire = f;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (launch_w[k] !== exp_launch[k] || drop_w[k] !== exp_drop[k] ||
          idx_w[k] !== 2'(m_last[k]) || shots_w[k] !== 16'(m_shots[k])) begin
        errors++;
        $display("FAIL outputs dut%0d cyc %0d got launch=%b drop=%b idx=%0d shots=%0d want launch=%b drop=%b idx=%0d shots=%0d",
                 k, cyc, launch_w[k], drop_w[k], idx_w[k], shots_w[k],
                 exp_launch[k], exp_drop[k], m_last[k], m_shots[k]);
      end
    end
  endtask

  task automatic test_reset();
    do_reset(1'b1);
  endtask

  task automatic test_first_shot();
    do_reset(1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if (launch_w[0] !== 4'b0001 || idx_w[0] !== 2'd0 || shots_w[0] !== 16'd1) begin
      errors++;
      $display("FAIL first_shot got launch=%b idx=%0d shots=%0d want 0001/0/1", launch_w[0], idx_w[0], shots_w[0]);
    end
    repeat (4) step(1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_four_presses();
    do_reset(1'b0);
    world_on = 1'b1; fly_len = 1000;
    repeat (4) begin
      step(1'b1, 1'b0, 1'b1);
      repeat (5) step(1'b0, 1'b0, 1'b1);
    end
    checks++;
    if (shots_w[0] !== 16'd4 || idx_w[0] !== 2'd3) begin
      errors++;
      $display("FAIL four_presses got shots=%0d idx=%0d want 4/3", shots_w[0], idx_w[0]);
    end
  endtask

  task automatic test_drop();
    do_reset(1'b0);
    force_busy[0] = 4'hF; force_busy[1] = 4'hF;
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if (drop_w[0] !== 1'b1 || launch_w[0] !== 4'b0 || shots_w[0] !== 16'd0) begin
      errors++;
      $display("FAIL drop got drop=%b launch=%b shots=%0d want 1/0000/0", drop_w[0], launch_w[0], shots_w[0]);
    end
    repeat (3) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_cooldown();
    do_reset(1'b0);
    for (int fr = 0; fr < 12; fr++)
      for (int c = 0; c < 6; c++)
        step(c == 2, c == 0, 1'b1);
    checks++;
    if (shots_w[1] !== 16'd2 || shots_w[0] !== 16'd12) begin
      errors++;
      $display("FAIL cooldown_shots got dut8=%0d dut0=%0d want 2/12", shots_w[1], shots_w[0]);
    end
  endtask

  task automatic test_reservation();
    do_reset(1'b0);
    force_busy[0] = 4'b1101; force_busy[1] = 4'b1101;
    step(1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (ready_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL reservation_release got ready=%b want 1", ready_w[0]);
    end
    step(1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_enable();
    do_reset(1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    repeat (3) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if (launch_w[1] !== 4'b0010) begin
      errors++;
      $display("FAIL enable_relaunch got launch=%b want 0010", launch_w[1]);
    end
    repeat (3) step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    step(1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (launch_w[k] !== 4'b0 || shots_w[k] !== 16'd0 || idx_w[k] !== 2'd3) begin
        errors++;
        $display("FAIL reset_mid dut%0d got launch=%b shots=%0d idx=%0d want 0000/0/3",
                 k, launch_w[k], shots_w[k], idx_w[k]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    model_init();
    step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic f;
    do_reset(1'b0);
    world_on = 1'b1; fly_len = 0;
    f = 1'b0;
    repeat (3000) begin
      if ($urandom_range(0, 3) == 0) f = ~f;
      for (int k = 0; k < 2; k++)
        force_busy[k] = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
      step(f, $urandom_range(0, 15) == 0, $urandom_range(0, 40) != 0);
    end
  endtask

  initial begin
    model_init();
    test_reset();
    test_first_shot();
    test_four_presses();
    test_drop();
    test_cooldown();
    test_reservation();
    test_enable();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
